// File: rtl/bt_top_pkg.sv
// Shared types and constants for the burst-transaction path.
package bt_top;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned BURST_LEN  = 16;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2,
    RSVD  = 2'd3
  } burst_mode_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]        addr;
    logic [$clog2(BURST_LEN)-1:0] len;
    logic [7:0]                   stride;
    burst_mode_t                  mode;
  } burst_desc_t;

endpackage

// File: rtl/burst_addr_gen_if.sv
// Descriptor request channel plus beat address channel of the burst address generator.
interface burst_addr_gen_if #(
  parameter int unsigned ADDR_WIDTH   = bt_top::ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH    = $clog2(bt_top::BURST_LEN),
  parameter int unsigned STRIDE_WIDTH = 8
) ();
  import bt_top::*;

  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [LEN_WIDTH-1:0]    req_len;
  logic [STRIDE_WIDTH-1:0] req_stride;
  burst_mode_t             req_mode;
  logic                    abort;
  logic                    beat_valid;
  logic                    beat_ready;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic                    beat_last;
  logic [LEN_WIDTH-1:0]    beat_idx;
  logic                    busy;
  logic                    err_pulse;

  modport master (
    output req_valid, req_addr, req_len, req_stride, req_mode, abort, beat_ready,
    input  req_ready, beat_valid, beat_addr, beat_last, beat_idx, busy, err_pulse
  );

  modport slave (
    input  req_valid, req_addr, req_len, req_stride, req_mode, abort, beat_ready,
    output req_ready, beat_valid, beat_addr, beat_last, beat_idx, busy, err_pulse
  );

endinterface

// File: rtl/burst_addr_gen_calc.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
module burst_addr_calc #(
  parameter int unsigned ADDR_WIDTH = bt_top::ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] wrap_mask,
  input  bt_top::burst_mode_t   mode,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  import bt_top::*;

  logic [ADDR_WIDTH-1:0] sum;

  always_comb begin
    sum = cur_addr + stride;
    next_addr = cur_addr;
    unique case (mode)
      FIXED:   next_addr = cur_addr;
      INCR:    next_addr = sum;
      WRAP:    next_addr = base | (sum & wrap_mask);
      default: next_addr = cur_addr;
    endcase
  end

endmodule

// File: rtl/burst_addr_gen.sv
// Burst address generator: one descriptor in, one address per beat out, with
// FIXED/INCR/WRAP modes, backpressure, abort and illegal-descriptor rejection.
module burst_addr_gen #(
  parameter int unsigned ADDR_WIDTH    = bt_top::ADDR_WIDTH,
  parameter int unsigned MAX_BURST_LEN = bt_top::BURST_LEN,
  parameter int unsigned STRIDE_WIDTH  = 8,
  parameter int unsigned LEN_WIDTH     = $clog2(MAX_BURST_LEN)
) (
  input logic              clk,
  input logic              rstn,
  burst_addr_gen_if.slave  bus
);
  import bt_top::*;

  typedef enum logic {StIdle, StBurst} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q, base_q, mask_q, stride_q;
  logic [LEN_WIDTH-1:0]  len_q, idx_q;
  burst_mode_t           mode_q;
  logic                  err_q;

  logic [ADDR_WIDTH-1:0] next_addr, wrap_mask;
  logic [LEN_WIDTH:0]    beats;
  int unsigned           len_ones;
  logic                  len_ok, stride_ok, req_legal, last;

  // Legal WRAP lengths are 2^k, so popcount(len) is log2(beats) and span = stride << that.
  always_comb begin
    len_ones = 0;
    for (int i = 0; i < LEN_WIDTH; i++) len_ones += 32'(bus.req_len[i]);
    wrap_mask = (ADDR_WIDTH'(bus.req_stride) << len_ones) - ADDR_WIDTH'(1);
    beats     = {1'b0, bus.req_len} + (LEN_WIDTH + 1)'(1);
    len_ok    = (bus.req_len != '0) && ((beats & {1'b0, bus.req_len}) == '0);
    stride_ok = (bus.req_stride != '0) &&
                ((bus.req_stride & (bus.req_stride - STRIDE_WIDTH'(1))) == '0);
    req_legal = (bus.req_mode != RSVD) && ((bus.req_mode != WRAP) || (len_ok && stride_ok));
  end

  assign last = (idx_q == len_q);

  burst_addr_calc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_calc (
    .cur_addr  (addr_q),
    .stride    (stride_q),
    .base      (base_q),
    .wrap_mask (mask_q),
    .mode      (mode_q),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      base_q   <= '0;
      mask_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      mode_q   <= FIXED;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            if (req_legal) begin
              state_q  <= StBurst;
              addr_q   <= bus.req_addr;
              base_q   <= bus.req_addr & ~wrap_mask;
              mask_q   <= wrap_mask;
              stride_q <= ADDR_WIDTH'(bus.req_stride);
              len_q    <= bus.req_len;
              idx_q    <= '0;
              mode_q   <= bus.req_mode;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StBurst: begin
          // A beat accepted alongside abort still counts as transferred.
          if (bus.beat_ready) begin
            if (last) begin
              state_q <= StIdle;
            end else begin
              idx_q  <= idx_q + LEN_WIDTH'(1);
              addr_q <= next_addr;
            end
          end
          if (bus.abort) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.busy       = (state_q == StBurst);
  assign bus.beat_valid = (state_q == StBurst);
  assign bus.beat_addr  = addr_q;
  assign bus.beat_idx   = idx_q;
  assign bus.beat_last  = (state_q == StBurst) && last;
  assign bus.err_pulse  = err_q;

`ifdef SVA_ON
  a_stall_stable: assert property (@(posedge clk) disable iff (!rstn)
    bus.beat_valid && !bus.beat_ready && !bus.abort |=>
      $stable(bus.beat_addr) && $stable(bus.beat_idx) && $stable(bus.beat_last));
  a_idx_bound: assert property (@(posedge clk) disable iff (!rstn) idx_q <= len_q);
  a_no_overlap: assert property (@(posedge clk) disable iff (!rstn)
    !(bus.req_ready && bus.beat_valid));
`endif

endmodule

// File: tb/tb_burst_addr_gen.sv
// Directed self-checking bench for burst_addr_gen.
module tb_burst_addr_gen;
  import bt_top::*;

  localparam int unsigned AW = 32;
  localparam int unsigned ML = 16;
  localparam int unsigned SW = 8;
  localparam int unsigned LW = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  burst_addr_gen_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .STRIDE_WIDTH(SW)) bus ();

  burst_addr_gen #(
    .ADDR_WIDTH    (AW),
    .MAX_BURST_LEN (ML),
    .STRIDE_WIDTH  (SW),
    .LEN_WIDTH     (LW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_addr [16];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    check_eq({tag, "_beat_valid"}, 64'(bus.beat_valid), 64'd0);
    check_eq({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check_eq({tag, "_beat_last"}, 64'(bus.beat_last), 64'd0);
  endtask

  task automatic send(input logic [31:0] addr, input logic [3:0] len,
                      input logic [7:0] stride, input logic [1:0] mode);
    @(negedge clk);
    check_eq("send_req_ready", 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_len    = len;
    bus.req_stride = stride;
    bus.req_mode   = burst_mode_t'(mode);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // beat_ready held high; checks n beats against exp_addr, then the idle bubble.
  task automatic expect_beats(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq({tag, "_valid"}, 64'(bus.beat_valid), 64'd1);
      check_eq({tag, "_addr"}, 64'(bus.beat_addr), 64'(exp_addr[i]));
      check_eq({tag, "_idx"}, 64'(bus.beat_idx), 64'(i));
      check_eq({tag, "_last"}, 64'(bus.beat_last), 64'(i == n - 1));
      check_eq({tag, "_req_ready_busy"}, 64'(bus.req_ready), 64'd0);
    end
    @(negedge clk);
    check_idle({tag, "_done"});
  endtask

  task automatic expect_reject(input string tag);
    @(negedge clk);
    check_eq({tag, "_err"}, 64'(bus.err_pulse), 64'd1);
    check_idle({tag, "_err_cycle"});
    @(negedge clk);
    check_eq({tag, "_err_clear"}, 64'(bus.err_pulse), 64'd0);
    check_eq({tag, "_no_beat"}, 64'(bus.beat_valid), 64'd0);
  endtask

  initial begin
    logic       rdy [5];
    int         eidx [5];
    int         hs;

    rstn           = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_len    = '0;
    bus.req_stride = '0;
    bus.req_mode   = FIXED;
    bus.abort      = 1'b0;
    bus.beat_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check_eq("reset_addr", 64'(bus.beat_addr), 64'd0);
    check_eq("reset_idx", 64'(bus.beat_idx), 64'd0);
    check_eq("reset_err", 64'(bus.err_pulse), 64'd0);
    rstn = 1'b1;

    // INCR basic
    bus.beat_ready = 1'b1;
    send(32'h100, 4'd3, 8'd4, 2'd1);
    exp_addr[0] = 32'h100; exp_addr[1] = 32'h104; exp_addr[2] = 32'h108; exp_addr[3] = 32'h10C;
    expect_beats("incr", 4);

    // WRAP: span 0x20, base 0x20
    send(32'h38, 4'd3, 8'd8, 2'd2);
    exp_addr[0] = 32'h38; exp_addr[1] = 32'h20; exp_addr[2] = 32'h28; exp_addr[3] = 32'h30;
    expect_beats("wrap", 4);

    // FIXED with backpressure
    rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    eidx = '{0, 1, 1, 1, 2};
    hs   = 0;
    send(32'hABC, 4'd2, 8'd4, 2'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.beat_ready = rdy[c];
      check_eq("fixed_valid", 64'(bus.beat_valid), 64'd1);
      check_eq("fixed_addr", 64'(bus.beat_addr), 64'hABC);
      check_eq("fixed_idx", 64'(bus.beat_idx), 64'(eidx[c]));
      check_eq("fixed_last", 64'(bus.beat_last), 64'(eidx[c] == 2));
      if (bus.beat_valid && bus.beat_ready) hs++;
    end
    @(negedge clk);
    check_idle("fixed_done");
    check_eq("fixed_beats", 64'(hs), 64'd3);
    bus.beat_ready = 1'b1;

    // Illegal descriptors
    send(32'h40, 4'd2, 8'd8, 2'd2);
    expect_reject("ill_wrap_len");
    send(32'h40, 4'd3, 8'd6, 2'd2);
    expect_reject("ill_wrap_stride");
    send(32'h40, 4'd1, 8'd4, 2'd3);
    expect_reject("ill_rsvd");

    // INCR across top of address space
    send(32'hFFFF_FFF8, 4'd3, 8'd4, 2'd1);
    exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC;
    exp_addr[2] = 32'h0;         exp_addr[3] = 32'h4;
    expect_beats("incr_top", 4);

    // Single-beat burst
    send(32'h300, 4'd0, 8'd4, 2'd1);
    exp_addr[0] = 32'h300;
    expect_beats("len0", 1);

    // Max-length WRAP: span 0x40, base 0x1000
    send(32'h1038, 4'd15, 8'd4, 2'd2);
    for (int i = 0; i < 16; i++) exp_addr[i] = 32'h1000 | ((32'h38 + 32'(i) * 4) & 32'h3F);
    expect_beats("wrap16", 16);

    // Abort after beat 1
    send(32'h200, 4'd7, 8'd4, 2'd1);
    @(negedge clk);
    check_eq("abort_b0_addr", 64'(bus.beat_addr), 64'h200);
    @(negedge clk);
    check_eq("abort_b1_addr", 64'(bus.beat_addr), 64'h204);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    check_idle("abort");
    check_eq("abort_err", 64'(bus.err_pulse), 64'd0);

    // Abort in IDLE has no effect on the next burst
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_idle("abort_idle");

    // Reset mid-burst
    send(32'h500, 4'd7, 8'd4, 2'd1);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_pre_valid", 64'(bus.beat_valid), 64'd1);
    rstn = 1'b0;
    #1;
    check_idle("rst_mid");
    check_eq("rst_mid_addr", 64'(bus.beat_addr), 64'd0);
    check_eq("rst_mid_idx", 64'(bus.beat_idx), 64'd0);
    check_eq("rst_mid_err", 64'(bus.err_pulse), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_idle("rst_after");
    check_eq("rst_after_err", 64'(bus.err_pulse), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
